// File: rtl/cp_pkg.sv
// cp_pkg: shared types and constants for the command-processor FIFO reader
package cp_pkg;
  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} cp_rd_state_t;
  localparam int CP_LINE_BYTES = 32;
  localparam int CP_BEATS_PER_LINE = 2;
  localparam int CP_WORDS_PER_LINE = 8;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B = 3'd4;
  localparam logic [7:0] AXI_LEN_LINE = 8'(CP_BEATS_PER_LINE - 1);
endpackage

// File: rtl/cp_line_buffer.sv
// cp_line_buffer: one 256-bit line, loaded per 128-bit beat and drained as 32-bit words
module cp_line_buffer
  import cp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         beat,
  input  logic [127:0] beat_data,
  input  logic         commit,
  input  logic         flush,
  output logic [31:0]  data,
  output logic         valid,
  input  logic         ready,
  output logic         done
);
  logic [255:0] line;
  logic [2:0]   k;
  assign data = line[{k, 5'b0} +: 32];
  assign done = valid && ready && k == 3'(CP_WORDS_PER_LINE - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      line  <= '0;
      valid <= 1'b0;
      k     <= '0;
    end else begin
      if (load) line[{beat, 7'b0} +: 128] <= beat_data;
      if (flush || commit) begin
        valid <= commit && !flush;
        k     <= '0;
      end else if (valid && ready) begin
        k     <= k + 3'd1;
        valid <= !done;
      end
    end
endmodule

// File: rtl/cp_fifo_reader.sv
// cp_fifo_reader: fetches FIFO lines over AXI, tracks read pointer/distance, streams command words
module cp_fifo_reader
  import cp_pkg::*;
#(
  parameter int LINE_BYTES = CP_LINE_BYTES,
  parameter int AXI_ADDR_W = 49
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           FIFOBase,
  input  logic [31:0]           FIFOEnd,
  input  logic [31:0]           FIFOWritePointer,
  input  logic [31:0]           FIFOHighWatermark,
  input  logic [31:0]           FIFOLowWatermark,
  input  logic [31:0]           FIFOBreakpoint,
  input  logic [31:0]           FIFOAXIBase,
  input  logic                  EnGPFIFO,
  input  logic                  EnBP,
  input  logic                  FIFONewBase,
  output logic [31:0]           FIFOReadPointer,
  output logic [31:0]           FIFORWDistance,
  output logic                  IntBP,
  output logic                  IntFIFOOverflow,
  output logic                  IntFIFOUnderflow,
  output logic                  StatGPIdle,
  output logic                  StatGPReadIdle,
  output logic                  ReadError,
  output logic [AXI_ADDR_W-1:0] araddr_a,
  output logic [7:0]            arlen_a,
  output logic [2:0]            arsize_a,
  output logic [1:0]            arburst_a,
  output logic                  arvalid_a,
  input  logic                  arready_a,
  input  logic [127:0]          rdata_a,
  input  logic [1:0]            rresp_a,
  input  logic                  rlast_a,
  input  logic                  rvalid_a,
  output logic                  rready_a,
  output logic [31:0]           cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready
);
  localparam logic [31:0] LINE_MASK = ~32'(LINE_BYTES - 1);
  cp_rd_state_t state, nxt;
  logic        discard, beat, hs, last_hs, drop, bp_hit, lb_done;
  logic [31:0] d_next, rp_adv;
  assign arlen_a   = AXI_LEN_LINE;
  assign arsize_a  = AXI_SIZE_16B;
  assign arburst_a = AXI_BURST_INCR;
  assign hs      = state == R && rvalid_a;
  assign last_hs = hs && rlast_a;
  // a reload in flight (or on this very cycle) turns the current burst into a discard
  assign drop    = discard || FIFONewBase;
  assign bp_hit  = EnBP && ((FIFOReadPointer ^ FIFOBreakpoint) & LINE_MASK) == 32'd0;
  assign d_next  = FIFOWritePointer - FIFOReadPointer +
                   (FIFOWritePointer >= FIFOReadPointer ? 32'd0 : FIFOEnd - FIFOBase + 32'(LINE_BYTES));
  assign rp_adv  = FIFOReadPointer == FIFOEnd ? FIFOBase : FIFOReadPointer + 32'(LINE_BYTES);
  assign StatGPIdle = StatGPReadIdle && !cmd_valid && FIFORWDistance == 32'd0;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = EnGPFIFO && FIFORWDistance != 32'd0 && !bp_hit && !cmd_valid && !FIFONewBase ? AR : IDLE;
      AR:    nxt = arready_a ? R : AR;
      R:     nxt = last_hs ? (drop ? IDLE : DRAIN) : R;
      DRAIN: nxt = FIFONewBase || lb_done ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state            <= IDLE;
      araddr_a         <= '0;
      arvalid_a        <= 1'b0;
      rready_a         <= 1'b0;
      StatGPReadIdle   <= 1'b0;
      discard          <= 1'b0;
      beat             <= 1'b0;
      FIFOReadPointer  <= '0;
      FIFORWDistance   <= '0;
      IntFIFOOverflow  <= 1'b0;
      IntFIFOUnderflow <= 1'b0;
      IntBP            <= 1'b0;
      ReadError        <= 1'b0;
    end else begin
      state            <= nxt;
      arvalid_a        <= nxt == AR;
      rready_a         <= nxt == R;
      StatGPReadIdle   <= nxt == IDLE;
      discard          <= nxt != IDLE && drop;
      if (state == IDLE && nxt == AR)
        araddr_a <= AXI_ADDR_W'(FIFOAXIBase) + AXI_ADDR_W'(FIFOReadPointer & LINE_MASK);
      if (hs) beat <= !rlast_a;
      FIFOReadPointer  <= FIFONewBase ? FIFOBase : (last_hs && !discard ? rp_adv : FIFOReadPointer);
      FIFORWDistance   <= d_next;
      IntFIFOOverflow  <= FIFORWDistance > FIFOHighWatermark;
      IntFIFOUnderflow <= FIFORWDistance < FIFOLowWatermark;
      IntBP            <= EnBP && (IntBP || bp_hit);
      ReadError        <= ReadError || (hs && rresp_a != 2'b00);
    end
  cp_line_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (hs && !drop),
    .beat     (beat),
    .beat_data(rdata_a),
    .commit   (last_hs && !drop),
    .flush    (FIFONewBase),
    .data     (cmd_data),
    .valid    (cmd_valid),
    .ready    (cmd_ready),
    .done     (lb_done)
  );
endmodule

// File: tb/tb_cp_fifo_reader.sv
// tb_cp_fifo_reader: directed self-checking bench for the FIFO read engine
module tb_cp_fifo_reader;
  localparam logic [31:0] AXIB = 32'hFFFF_F000;
  logic clk = 1'b0, reset;
  logic [31:0] FIFOBase, FIFOEnd, FIFOWritePointer, FIFOHighWatermark, FIFOLowWatermark;
  logic [31:0] FIFOBreakpoint, FIFOAXIBase, FIFOReadPointer, FIFORWDistance, cmd_data;
  logic EnGPFIFO, EnBP, FIFONewBase, IntBP, IntFIFOOverflow, IntFIFOUnderflow;
  logic StatGPIdle, StatGPReadIdle, ReadError, arvalid_a, arready_a, rlast_a, rvalid_a, rready_a;
  logic cmd_valid, cmd_ready;
  logic [48:0] araddr_a;
  logic [7:0] arlen_a;
  logic [2:0] arsize_a;
  logic [1:0] arburst_a, rresp_a;
  logic [127:0] rdata_a;
  int errors = 0, checks = 0, cv_count = 0;

  cp_fifo_reader dut (
    .clk(clk), .reset(reset), .FIFOBase(FIFOBase), .FIFOEnd(FIFOEnd),
    .FIFOWritePointer(FIFOWritePointer), .FIFOHighWatermark(FIFOHighWatermark),
    .FIFOLowWatermark(FIFOLowWatermark), .FIFOBreakpoint(FIFOBreakpoint),
    .FIFOAXIBase(FIFOAXIBase), .EnGPFIFO(EnGPFIFO), .EnBP(EnBP), .FIFONewBase(FIFONewBase),
    .FIFOReadPointer(FIFOReadPointer), .FIFORWDistance(FIFORWDistance), .IntBP(IntBP),
    .IntFIFOOverflow(IntFIFOOverflow), .IntFIFOUnderflow(IntFIFOUnderflow),
    .StatGPIdle(StatGPIdle), .StatGPReadIdle(StatGPReadIdle), .ReadError(ReadError),
    .araddr_a(araddr_a), .arlen_a(arlen_a), .arsize_a(arsize_a), .arburst_a(arburst_a),
    .arvalid_a(arvalid_a), .arready_a(arready_a), .rdata_a(rdata_a), .rresp_a(rresp_a),
    .rlast_a(rlast_a), .rvalid_a(rvalid_a), .rready_a(rready_a),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cmd_valid) cv_count++;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ar_expect(input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    while (!arvalid_a && n < 50) begin @(negedge clk); n++; end
    check("arvalid", arvalid_a, 1);
    check("araddr", araddr_a, 64'(AXIB) + 64'(addr));
    check("arlen", arlen_a, 1);
    arready_a = 1'b1;
    @(posedge clk); #1 arready_a = 1'b0;
  endtask

  task automatic beat(input logic [31:0] wb, input logic hi, input logic [1:0] resp);
    int n = 0;
    rdata_a = hi ? {wb + 32'd7, wb + 32'd6, wb + 32'd5, wb + 32'd4}
                 : {wb + 32'd3, wb + 32'd2, wb + 32'd1, wb};
    rlast_a = hi; rresp_a = resp; rvalid_a = 1'b1;
    @(negedge clk);
    while (!rready_a && n < 50) begin @(negedge clk); n++; end
    check("rready", rready_a, 1);
    @(posedge clk); #1 rvalid_a = 1'b0; rlast_a = 1'b0; rresp_a = 2'b00;
  endtask

  task automatic drain(input logic [31:0] wb, input logic [3:0] pat);
    int idx = 0, cyc = 0;
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      cmd_ready = pat[cyc % 4];
      if (cmd_valid) begin
        check("cmd_data", cmd_data, wb + 32'(idx));
        if (cmd_ready) idx++;
      end
      cyc++;
    end
    check("drain_words", idx, 8);
    if (pat == 4'hF) check("drain_cycles", cyc, 8);
    @(negedge clk);
    cmd_ready = 1'b0;
    check("cmd_valid_after", cmd_valid, 0);
  endtask

  task automatic line(input logic [31:0] addr, input logic [31:0] wb, input logic [3:0] pat);
    ar_expect(addr);
    beat(wb, 1'b0, 2'b00);
    beat(wb, 1'b1, 2'b00);
    drain(wb, pat);
  endtask

  initial begin
    logic saw;
    int cv0;
    reset = 1; FIFOBase = 32'h1000; FIFOEnd = 32'h1FE0; FIFOWritePointer = 32'h1020;
    FIFOHighWatermark = 32'hFFFF_FFFF; FIFOLowWatermark = 0; FIFOBreakpoint = 0;
    FIFOAXIBase = AXIB; EnGPFIFO = 0; EnBP = 0; FIFONewBase = 0; arready_a = 0;
    rdata_a = '0; rresp_a = 0; rlast_a = 0; rvalid_a = 0; cmd_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_rp", FIFOReadPointer, 0);
    check("rst_dist", FIFORWDistance, 0);
    check("rst_flags", {arvalid_a, rready_a, cmd_valid, IntBP, IntFIFOOverflow, IntFIFOUnderflow,
                        StatGPIdle, StatGPReadIdle, ReadError}, 0);
    @(posedge clk); #1 reset = 0;
    // basic line fetch after pointer reload
    @(posedge clk); #1 FIFONewBase = 1;
    @(posedge clk); #1 FIFONewBase = 0;
    @(posedge clk); #1;
    check("t1_rp", FIFOReadPointer, 32'h1000);
    check("t1_dist", FIFORWDistance, 32'h20);
    check("t1_readidle", StatGPReadIdle, 1);
    check("t1_gpidle_busy", StatGPIdle, 0);
    EnGPFIFO = 1;
    ar_expect(32'h1000);
    check("arsize", arsize_a, 4);
    check("arburst", arburst_a, 1);
    beat(0, 1'b0, 2'b00);
    beat(0, 1'b1, 2'b00);
    drain(0, 4'hF);
    @(negedge clk);
    check("t1_rp_adv", FIFOReadPointer, 32'h1020);
    check("t1_dist0", FIFORWDistance, 0);
    check("t1_gpidle", StatGPIdle, 1);
    // wrap from End back to Base, with a stalling sink
    EnGPFIFO = 0; FIFOBase = 32'h1FE0; FIFONewBase = 1;
    @(posedge clk); #1 FIFONewBase = 0; FIFOBase = 32'h1000; FIFOWritePointer = 32'h1000;
    @(posedge clk); @(negedge clk);
    check("t2_rp", FIFOReadPointer, 32'h1FE0);
    check("t2_dist", FIFORWDistance, 32'h20);
    EnGPFIFO = 1;
    line(32'h1FE0, 32'h100, 4'b1001);
    @(negedge clk);
    check("t2_rp_wrap", FIFOReadPointer, 32'h1000);
    check("t2_dist0", FIFORWDistance, 0);
    // breakpoint stops fetch after two lines
    EnBP = 1; FIFOBreakpoint = 32'h1040; FIFOWritePointer = 32'h1080;
    line(32'h1000, 32'h200, 4'hF);
    line(32'h1020, 32'h300, 4'hF);
    saw = 0;
    repeat (20) begin @(negedge clk); saw |= arvalid_a; end
    check("t4_no_third_ar", saw, 0);
    check("t4_intbp", IntBP, 1);
    check("t4_rp", FIFOReadPointer, 32'h1040);
    EnBP = 0;
    @(negedge clk);
    check("t4_intbp_clr", IntBP, 0);
    line(32'h1040, 32'h400, 4'hF);
    line(32'h1060, 32'h500, 4'hF);
    @(negedge clk);
    check("t4_rp_end", FIFOReadPointer, 32'h1080);
    check("t4_dist0", FIFORWDistance, 0);
    // watermarks: D steps to 0x60 then back to 0
    EnGPFIFO = 0; FIFOHighWatermark = 32'h40; FIFOLowWatermark = 32'h20;
    FIFOWritePointer = 32'h10E0;
    @(negedge clk);
    check("t5_dist60", FIFORWDistance, 32'h60);
    check("t5_ovf_lag", IntFIFOOverflow, 0);
    @(negedge clk);
    check("t5_ovf1", IntFIFOOverflow, 1);
    check("t5_udf0", IntFIFOUnderflow, 0);
    FIFOWritePointer = 32'h1080;
    repeat (2) @(negedge clk);
    check("t5_ovf0", IntFIFOOverflow, 0);
    check("t5_udf1", IntFIFOUnderflow, 1);
    // reload between beats discards the burst; error response is sticky
    check("t6_readerr0", ReadError, 0);
    @(posedge clk); #1 EnGPFIFO = 1; FIFOWritePointer = 32'h10A0;
    @(negedge clk); @(negedge clk);
    check("t6_ar_lag", arvalid_a, 0);
    @(negedge clk);
    check("t6_ar_rise", arvalid_a, 1);
    ar_expect(32'h1080);
    cv0 = cv_count;
    beat(32'h600, 1'b0, 2'b10);
    FIFONewBase = 1;
    @(posedge clk); #1 FIFONewBase = 0;
    beat(32'h600, 1'b1, 2'b00);
    check("t6_readerr", ReadError, 1);
    check("t6_rp_base", FIFOReadPointer, 32'h1000);
    ar_expect(32'h1000);
    check("t6_no_cmd", cv_count, cv0);
    EnGPFIFO = 0;
    beat(32'h700, 1'b0, 2'b00);
    beat(32'h700, 1'b1, 2'b00);
    drain(32'h700, 4'hF);
    repeat (5) @(negedge clk);
    check("t6_rp", FIFOReadPointer, 32'h1020);
    check("t6_dist", FIFORWDistance, 32'h80);
    check("t6_no_ar", arvalid_a, 0);
    check("t6_readerr_sticky", ReadError, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cp_fifo_reader.md
# cp_fifo_reader

Command-processor FIFO read engine. It is the consumer end of the GX command FIFO that the write-gather path fills through the AXI write port. It fetches 32-byte lines from the FIFO region in memory over the CP AXI read channel, tracks the read pointer and the read/write distance, and raises the watermark and breakpoint interrupts. Fetched words are delivered as a 32-bit valid/ready stream to the command decoder. It sits in CPTop beside the register block, which consumes its pointer, distance, interrupt and idle outputs.

## Interface
Parameters:
- `LINE_BYTES`, 32: FIFO line size; pointers advance in this unit.
- `AXI_ADDR_W`, 49: AXI address width.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `FIFOBase`, `FIFOEnd`, `FIFOWritePointer` in 32 each: FIFO region bounds and write pointer.
  - `FIFOEnd` is the address of the last line.
- `FIFOHighWatermark`, `FIFOLowWatermark`, `FIFOBreakpoint` in 32 each: thresholds and breakpoint address.
- `FIFOAXIBase` in 32: AXI byte address of CPU address 0.
- `EnGPFIFO`, `EnBP` in 1 each: fetch enable and breakpoint enable.
- `FIFONewBase` in 1: one-cycle pulse that reloads the read pointer.
- `FIFOReadPointer`, `FIFORWDistance` out 32 each.
- `IntBP`, `IntFIFOOverflow`, `IntFIFOUnderflow`, `StatGPIdle`, `StatGPReadIdle`, `ReadError` out 1 each.
- AXI read address: `araddr_a` out 49, `arlen_a` out 8, `arsize_a` out 3, `arburst_a` out 2, `arvalid_a` out 1, `arready_a` in 1.
- AXI read data: `rdata_a` in 128, `rresp_a` in 2, `rlast_a` in 1, `rvalid_a` in 1, `rready_a` out 1.
- Command stream: `cmd_data` out 32, `cmd_valid` out 1, `cmd_ready` in 1.

## Operation
- Every read is a single 2-beat INCR burst: `arlen_a`=1, `arsize_a`=4 (16 B), `arburst_a`=01.
- Address: `araddr_a` = zero-extended `FIFOAXIBase` + {`FIFOReadPointer`[31:5], 5'b0}. The address is registered at AR entry.
- Distance: D = WP − RP when WP ≥ RP, otherwise (WP − RP) + (FIFOEnd − FIFOBase + 32). Computed in 32 bits and registered into `FIFORWDistance`.
- Breakpoint hit: `EnBP` && RP[31:5] == `FIFOBreakpoint`[31:5].
  - `IntBP` is set on hit and held until `EnBP` is low.
- Watermark interrupts, registered from `FIFORWDistance`:
  - `IntFIFOOverflow` = D > HighWatermark.
  - `IntFIFOUnderflow` = D < LowWatermark.
- State machine:
  - IDLE: move to AR when `EnGPFIFO` && D ≠ 0 && !bp_hit && line buffer empty.
  - AR: `arvalid_a`=1 until `arready_a`, then R.
  - R: `rready_a`=1. Beat 0 loads buffer bits [127:0], beat 1 loads [255:128]. On `rlast_a`, go to DRAIN.
  - On R exit, RP advances: RP = (RP == FIFOEnd) ? FIFOBase : RP + 32.
  - DRAIN: `cmd_data` = buffer word k (bits [32k+31:32k], k=0..7, no byte swap). k increments on `cmd_valid`&&`cmd_ready`. After word 7 is accepted, go to IDLE.
- `rresp_a` ≠ 00 on any beat sets sticky `ReadError`, cleared only by reset. The data is still delivered.
- `FIFONewBase`:
  - RP ← FIFOBase on the next edge and the buffer is flushed (`cmd_valid` drops).
  - If pressed in AR or R, the burst completes with beats discarded and no RP advance, then the FSM returns to IDLE.
  - If it coincides with an RP advance, the reload wins.
- `EnGPFIFO` going low does not abort a burst or drain. It only blocks new AR issue.
- `StatGPReadIdle` = (state == IDLE).
- `StatGPIdle` = StatGPReadIdle && buffer empty && D == 0.

## Timing
- Reset values: all outputs 0, state IDLE, RP = 0, buffer empty. `arsize_a`, `arlen_a` and `arburst_a` are constants.
- IDLE→AR: `arvalid_a` rises 1 cycle after the condition holds on a registered D. A WP write therefore shows on `arvalid_a` 2 cycles later.
- AXI rules: `arvalid_a` is never withdrawn before `arready_a`. `araddr_a` is stable while valid.
- After the `rlast_a` handshake, `cmd_valid` goes high the next cycle. `FIFOReadPointer` updates the same edge.
- Stream rules: `cmd_data` is stable while `cmd_valid` && !`cmd_ready`. Throughput is 1 word/cycle.
- Per-line latency with a ready slave and sink: 1 (AR) + AR wait + 2 beats + 8 drain cycles. No overlap of fetch and drain.
- An RP change affects D, and the interrupts, 1 and 2 cycles later respectively.

## Structure
- Package `cp_pkg` holds:
  - the `cp_rd_state_t` enum (IDLE, AR, R, DRAIN);
  - `CP_LINE_BYTES`=32, `CP_BEATS_PER_LINE`=2, `CP_WORDS_PER_LINE`=8;
  - the AXI constants (`AXI_BURST_INCR`, `AXI_SIZE_16B`).
- Sub-module `cp_line_buffer`: 256-bit beat-indexed load, word-indexed drain, valid/ready output, flush input.

## Test plan
- Base=0x1000, End=0x1FE0, WP=0x1020, RP reloaded via `FIFONewBase`:
  - expect one AR at FIFOAXIBase+0x1000 with arlen 1;
  - rdata beats 0x3..0_0x..0 pattern yield `cmd_data` words 0..7 in lane order;
  - then RP=0x1020, D=0, `StatGPIdle`=1.
- RP=End=0x1FE0, WP=0x1000: the fetch reads 0x1FE0, RP wraps to 0x1000, and D passes through 0x20 and ends at 0.
- `cmd_ready` toggled 1-0-0-1: each word is held stable and none is dropped or duplicated.
- EnBP=1, Breakpoint=0x1040, WP=0x1080: two lines fetched, `IntBP`=1, no third AR. `EnBP`=0 clears `IntBP` and fetch resumes.
- High=0x40, Low=0x20, WP steps RP+0x60 then RP+0x00:
  - overflow 1, then 0;
  - underflow 0, then 1.
- `FIFONewBase` asserted between beats: beat 1 is discarded, RP=FIFOBase, no `cmd_valid`, next AR at base. `rresp_a`=10 sets `ReadError`.
